viterbi_codec: RTL and testbench
================================

Name: viterbi_codec

Overview:
- Rate-1/2, constraint-length-4 convolutional encoder and matching hard-decision Viterbi decoder in one block. The two halves share only clock and reset.
- The encoder feeds a channel model, which may corrupt symbols; the decoder receives the channel output and recovers the original bit stream.
- The survivor path uses register-exchange storage with a fixed decision depth.

Parameters:
- TB_DEPTH, 32, survivor register length in bits, equal to decoder latency in accepted symbols; legal range 8..64.
- PM_W, 8, path-metric width in bits; legal range 6..12.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- enc_enable_i  in  1  encoder input bit valid this cycle.
- enc_d_i  in  1  encoder data bit.
- enc_valid_o  out  1  enc_d_o carries a valid symbol.
- enc_d_o  out  2  coded symbol; [1]=g1 parity, [0]=g0 parity.
- dec_enable_i  in  1  decoder input symbol valid this cycle.
- dec_d_i  in  2  received hard symbol, same bit order as enc_d_o.
- dec_valid_o  out  1  dec_d_o carries a decoded bit.
- dec_d_o  out  1  decoded bit.

Behaviour:
- Reset: asynchronous and active-high; clears everything immediately, including mid-operation.
  - Encoder state = 000; enc_valid_o = 0; enc_d_o = 00.
  - pm[0] = 0; pm[1..7] = 16.
  - All survivor registers = 0; symbol counter = 0; dec_valid_o = 0; dec_d_o = 0.
- Encoder state s[2:0] = {b(t-1), b(t-2), b(t-3)}.
- On a clk edge with enc_enable_i = 1 and input bit b:
  - enc_d_o[1] <= b^s2^s1^s0 (generator 17 octal).
  - enc_d_o[0] <= b^s2^s0 (generator 15 octal).
  - s <= {b, s2, s1}.
  - enc_valid_o <= 1. Latency is 1 cycle.
- Encoder with enc_enable_i = 0: state and enc_d_o hold; enc_valid_o <= 0.
- Decoder trellis: 8 states n = {n2, n1, n0}, same convention as the encoder. Predecessors of n are p0 = {n1, n0, 0} and p1 = {n1, n0, 1}. The decided bit entering n is n2.
- Decoder branch metric: Hamming distance (0..2) between dec_d_i and the expected symbol of the transition p->n, computed with the encoder equations (b = n2, s = p).
- Decoder update, on a clk edge with dec_enable_i = 1:
  - Add-compare-select: cand_x = pm[px] + bm(px->n). Select the smaller candidate; on a tie select p0.
  - Normalisation: subtract the minimum of the 8 new metrics from all 8 before storing. Metrics never exceed 2^PM_W - 1; saturate at that value if reached.
  - Survivor: path[n] <= {path[psel][TB_DEPTH-2:0], n2}.
  - best = state with the minimum new metric; ties go to the lowest index.
  - dec_d_o <= new path[best][TB_DEPTH-1], i.e. the bit of the symbol accepted TB_DEPTH-1 updates earlier.
  - Symbol counter increments, saturating at TB_DEPTH.
  - dec_valid_o <= 1 once the counter reaches TB_DEPTH-1 before this update, i.e. on the TB_DEPTH-th accepted symbol and every accepted symbol after.
- Decoder with dec_enable_i = 0: all state holds; dec_valid_o <= 0; dec_d_o holds.
- End-to-end latency: bit k appears on dec_d_o after the edge that accepts symbol k+TB_DEPTH-1.
- Tail: no tail flush is required; the last TB_DEPTH-1 bits are emitted only when further symbols are supplied.
- Correction: error-free input decodes exactly; isolated errors are corrected, with d_free = 6.

Test Plan:
- Encoder impulse: reset, enable with bits 1,0,0,0,0 -> enc_d_o = 11, 11, 10, 11, 00, with enc_valid_o = 1 one cycle after each enable.
- Encoder enable gap: enable low for 3 cycles mid-stream -> enc_valid_o = 0 and state held; the resumed output equals the gap-free sequence.
- Clean loopback: 1000 random bits through the encoder into the decoder, TB_DEPTH = 32 -> dec_valid_o rises on the 32nd accepted symbol; dec_d_o equals the input delayed by 31 symbols, zero mismatches; pm[best] stays 0.
- Error correction: same stream with one random bit flipped every 16th symbol -> zero decoded bit errors.
- Metric bound: 5000 symbols of random garbage on dec_d_i -> no stored metric exceeds 2^PM_W - 1 and the minimum stored metric is always 0.
- Reset mid-stream: assert rst asynchronously between edges -> all outputs 0 and pm[0] = 0 immediately; after release, decoding restarts with dec_valid_o rising after 32 new symbols.

Source files
------------

// File: rtl/viterbi_codec_if.sv
// rtl/viterbi_codec_if.sv - encoder/decoder stream signals for viterbi_codec
interface viterbi_codec_if;
    logic       enc_enable_i;
    logic       enc_d_i;
    logic       enc_valid_o;
    logic [1:0] enc_d_o;
    logic       dec_enable_i;
    logic [1:0] dec_d_i;
    logic       dec_valid_o;
    logic       dec_d_o;

    modport master (
        output enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        input  enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
    );

    modport slave (
        input  enc_enable_i, enc_d_i, dec_enable_i, dec_d_i,
        output enc_valid_o, enc_d_o, dec_valid_o, dec_d_o
    );
endinterface

// File: rtl/viterbi_codec.sv
// rtl/viterbi_codec.sv - rate-1/2 K=4 convolutional encoder and register-exchange Viterbi decoder
module viterbi_codec #(
    parameter int TB_DEPTH = 32,
    parameter int PM_W     = 8
) (
    input  logic            clk,
    input  logic            rst,
    viterbi_codec_if.slave  bus
);
    localparam int              CW     = PM_W + 2;
    localparam int              CNT_W  = $clog2(TB_DEPTH + 1);
    localparam logic [CW-1:0]   PM_MAX = CW'((1 << PM_W) - 1);

    function automatic logic [1:0] f_sym(input logic b, input logic [2:0] s);
        return {b ^ s[2] ^ s[1] ^ s[0], b ^ s[2] ^ s[0]};
    endfunction

    function automatic logic [1:0] f_bm(input logic [1:0] a, input logic [1:0] e);
        logic [1:0] x;
        x = a ^ e;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

    logic [2:0] r_enc_s;
    logic       r_enc_valid;
    logic [1:0] r_enc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enc_s     <= '0;
            r_enc_valid <= 1'b0;
            r_enc_d     <= '0;
        end else begin
            r_enc_valid <= bus.enc_enable_i;
            if (bus.enc_enable_i) begin
                r_enc_d <= f_sym(bus.enc_d_i, r_enc_s);
                r_enc_s <= {bus.enc_d_i, r_enc_s[2:1]};
            end
        end
    end

    assign bus.enc_valid_o = r_enc_valid;
    assign bus.enc_d_o     = r_enc_d;

    // Stored survivors omit the oldest bit; it only ever feeds dec_d_o.
    logic [PM_W-1:0]     r_pm   [8];
    logic [TB_DEPTH-2:0] r_path [8];
    logic [CNT_W-1:0]    r_cnt;
    logic                r_dec_valid;
    logic                r_dec_d;

    logic [CW-1:0]       w_cand0 [8];
    logic [CW-1:0]       w_cand1 [8];
    logic [CW-1:0]       w_sel   [8];
    logic [PM_W-1:0]     w_pm_new   [8];
    logic [TB_DEPTH-2:0] w_path_new [8];
    logic [2:0]          w_psel  [8];
    logic [CW-1:0]       w_min;
    logic [CW-1:0]       w_norm;
    logic [2:0]          w_best;

    always_comb begin
        w_min  = '0;
        w_best = '0;
        w_norm = '0;
        for (int n = 0; n < 8; n++) begin
            w_cand0[n] = CW'(r_pm[{n[1:0], 1'b0}])
                       + CW'(f_bm(bus.dec_d_i, f_sym(n[2], {n[1:0], 1'b0})));
            w_cand1[n] = CW'(r_pm[{n[1:0], 1'b1}])
                       + CW'(f_bm(bus.dec_d_i, f_sym(n[2], {n[1:0], 1'b1})));
            w_psel[n]  = {n[1:0], (w_cand1[n] < w_cand0[n])};
            w_sel[n]   = (w_cand1[n] < w_cand0[n]) ? w_cand1[n] : w_cand0[n];
            w_path_new[n] = {r_path[w_psel[n]][TB_DEPTH-3:0], n[2]};
        end
        w_min = w_sel[0];
        for (int n = 1; n < 8; n++) begin
            if (w_sel[n] < w_min) begin
                w_min  = w_sel[n];
                w_best = 3'(n);
            end
        end
        for (int n = 0; n < 8; n++) begin
            w_norm      = w_sel[n] - w_min;
            w_pm_new[n] = (w_norm > PM_MAX) ? PM_MAX[PM_W-1:0] : w_norm[PM_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 8; n++) begin
                r_pm[n]   <= (n == 0) ? '0 : PM_W'(16);
                r_path[n] <= '0;
            end
            r_cnt       <= '0;
            r_dec_valid <= 1'b0;
            r_dec_d     <= 1'b0;
        end else begin
            r_dec_valid <= bus.dec_enable_i && (r_cnt >= CNT_W'(TB_DEPTH - 1));
            if (bus.dec_enable_i) begin
                for (int n = 0; n < 8; n++) begin
                    r_pm[n]   <= w_pm_new[n];
                    r_path[n] <= w_path_new[n];
                end
                r_dec_d <= r_path[w_psel[w_best]][TB_DEPTH-2];
                if (r_cnt != CNT_W'(TB_DEPTH))
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.dec_valid_o = r_dec_valid;
    assign bus.dec_d_o     = r_dec_d;
endmodule

// File: tb/tb_viterbi_codec.sv
// tb/tb_viterbi_codec.sv - directed self-checking bench for viterbi_codec
module tb_viterbi_codec;
    localparam int TB_DEPTH = 32;
    localparam int PM_W     = 8;
    localparam int PM_MAX   = (1 << PM_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    viterbi_codec_if bus ();

    viterbi_codec #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_vec = 0;
    int   n_err = 0;
    logic bits [0:1023];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int pm_min();
        int m = PM_MAX + 1;
        for (int i = 0; i < 8; i++) if (int'(dut.r_pm[i]) < m) m = int'(dut.r_pm[i]);
        return m;
    endfunction

    function automatic int pm_max();
        int m = 0;
        for (int i = 0; i < 8; i++) if (int'(dut.r_pm[i]) > m) m = int'(dut.r_pm[i]);
        return m;
    endfunction

    task automatic idle_inputs;
        bus.enc_enable_i = 1'b0;
        bus.enc_d_i      = 1'b0;
        bus.dec_enable_i = 1'b0;
        bus.dec_d_i      = 2'b00;
    endtask

    task automatic do_reset;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic loopback(input int n, input bit flip, input bit chk_pm);
        logic [1:0] sym;
        int j;
        for (int t = 0; t <= n; t++) begin
            bus.enc_enable_i = (t < n);
            bus.enc_d_i      = (t < n) ? bits[t] : 1'b0;
            sym = bus.enc_d_o;
            if (flip && t > 0 && ((t - 1) % 16 == 15))
                sym = sym ^ (2'b01 << $urandom_range(1, 0));
            bus.dec_enable_i = (t > 0);
            bus.dec_d_i      = sym;
            tick();
            if (t > 0) begin
                j = t - 1;
                if (j < TB_DEPTH - 1) begin
                    check("dec_valid_early", 32'(bus.dec_valid_o), 32'd0);
                end else begin
                    check("dec_valid", 32'(bus.dec_valid_o), 32'd1);
                    check("dec_bit", 32'(bus.dec_d_o), 32'(bits[j - TB_DEPTH + 1]));
                end
                if (chk_pm) check("pm_best_zero", 32'(pm_min()), 32'd0);
            end
        end
        idle_inputs();
    endtask

    logic       imp_in  [5];
    logic [1:0] imp_exp [5];
    logic       gap_in  [6];
    logic [1:0] gap_exp [6];

    initial begin
        imp_in  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        imp_exp = '{2'b11, 2'b11, 2'b10, 2'b11, 2'b00};
        gap_in  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        gap_exp = '{2'b11, 2'b11, 2'b01, 2'b11, 2'b01, 2'b10};
        for (int i = 0; i < 1024; i++) bits[i] = 1'($urandom_range(1, 0));

        do_reset();
        check("rst_enc_valid", 32'(bus.enc_valid_o), 32'd0);
        check("rst_enc_d", 32'(bus.enc_d_o), 32'd0);
        check("rst_dec_valid", 32'(bus.dec_valid_o), 32'd0);
        check("rst_dec_d", 32'(bus.dec_d_o), 32'd0);
        check("rst_pm0", 32'(dut.r_pm[0]), 32'd0);
        check("rst_pm7", 32'(dut.r_pm[7]), 32'd16);

        for (int i = 0; i < 5; i++) begin
            bus.enc_enable_i = 1'b1;
            bus.enc_d_i      = imp_in[i];
            tick();
            check("imp_valid", 32'(bus.enc_valid_o), 32'd1);
            check("imp_sym", 32'(bus.enc_d_o), 32'(imp_exp[i]));
        end
        bus.enc_enable_i = 1'b0;
        tick();
        check("imp_valid_off", 32'(bus.enc_valid_o), 32'd0);

        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                for (int g = 0; g < 3; g++) begin
                    bus.enc_enable_i = 1'b0;
                    bus.enc_d_i      = 1'b1;
                    tick();
                    check("gap_valid", 32'(bus.enc_valid_o), 32'd0);
                    check("gap_hold", 32'(bus.enc_d_o), 32'(gap_exp[2]));
                end
            end
            bus.enc_enable_i = 1'b1;
            bus.enc_d_i      = gap_in[i];
            tick();
            check("gap_valid_on", 32'(bus.enc_valid_o), 32'd1);
            check("gap_sym", 32'(bus.enc_d_o), 32'(gap_exp[i]));
        end
        idle_inputs();

        do_reset();
        loopback(1000, 1'b0, 1'b1);

        do_reset();
        loopback(1000, 1'b1, 1'b0);

        do_reset();
        for (int i = 0; i < 5000; i++) begin
            bus.dec_enable_i = 1'b1;
            bus.dec_d_i      = 2'($urandom_range(3, 0));
            tick();
            check("pm_bound", 32'(pm_max() <= PM_MAX), 32'd1);
            check("pm_min_zero", 32'(pm_min()), 32'd0);
        end
        idle_inputs();

        do_reset();
        loopback(50, 1'b0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_enc_valid", 32'(bus.enc_valid_o), 32'd0);
        check("arst_enc_d", 32'(bus.enc_d_o), 32'd0);
        check("arst_dec_valid", 32'(bus.dec_valid_o), 32'd0);
        check("arst_dec_d", 32'(bus.dec_d_o), 32'd0);
        check("arst_pm0", 32'(dut.r_pm[0]), 32'd0);
        check("arst_pm3", 32'(dut.r_pm[3]), 32'd16);
        #2;
        rst = 1'b0;
        loopback(100, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
